// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the UART receive front end.
// Holds the legal oversampling ratios, bit-counter sizing and the majority vote.
package uart_rx_pkg;

  localparam int unsigned PRESCALE_8  = 8;
  localparam int unsigned PRESCALE_16 = 16;
  localparam int unsigned PRESCALE_32 = 32;

  localparam int          BIT_CNT_W        = 4;
  localparam int unsigned BIT_CNT_MAX      = 15;
  // Bit index at which the receive FSM leaves its deserialize state.
  localparam int unsigned BIT_CNT_DATA_END = 9;

  function automatic logic prescale_is_legal(input int unsigned p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_data_sampler.sv
// Three-point mid-bit sampler: captures the line at H-2 and H-1, votes at H,
// and flags the fresh result one cycle later.
module uart_rx_data_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic [PRESCALE_W-1:0] half_prescale,
  input  logic                  data_samp_en,
  input  logic                  rx_in,
  output logic                  sampled_bit,
  output logic                  sample_done
);

  logic s0_q, s0_d;
  logic s1_q, s1_d;
  logic sampled_bit_q, sampled_bit_d;
  logic sample_done_q, sample_done_d;
  logic at_first, at_second, at_vote;

  assign at_first  = (edge_cnt == (half_prescale - PRESCALE_W'(2)));
  assign at_second = (edge_cnt == (half_prescale - PRESCALE_W'(1)));
  assign at_vote   = (edge_cnt == half_prescale);

  always_comb begin
    s0_d          = s0_q;
    s1_d          = s1_q;
    sampled_bit_d = sampled_bit_q;
    sample_done_d = 1'b0;
    if (data_samp_en) begin
      if (at_first) begin
        s0_d = rx_in;
      end
      if (at_second) begin
        s1_d = rx_in;
      end
      // The third sample is taken live so the vote lands in the same cycle.
      if (at_vote) begin
        sampled_bit_d = majority3(s0_q, s1_q, rx_in);
        sample_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q          <= 1'b1;
      s1_q          <= 1'b1;
      sampled_bit_q <= 1'b1;
      sample_done_q <= 1'b0;
    end else begin
      s0_q          <= s0_d;
      s1_q          <= s1_d;
      sampled_bit_q <= sampled_bit_d;
      sample_done_q <= sample_done_d;
    end
  end

  assign sampled_bit = sampled_bit_q;
  assign sample_done = sample_done_q;

endmodule

// File: rtl/uart_rx_edge_sampler.sv
// UART receive timing front end: oversampling edge counter, frame bit counter,
// per-frame prescale latch and the majority-vote data sampler.
module uart_rx_edge_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  RX_IN,
  input  logic                  data_samp_en,
  input  logic                  cnt_enable,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  last_edge_flag,
  output logic                  sampled_bit,
  output logic                  sample_done
);

  localparam logic [PRESCALE_W-1:0] PRESCALE_RST = PRESCALE_W'(PRESCALE_8);
  localparam logic [BIT_CNT_W-1:0]  BIT_CNT_SAT  = BIT_CNT_W'(BIT_CNT_MAX);

  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [PRESCALE_W-1:0] half_prescale;
  logic [PRESCALE_W-1:0] last_edge_idx;
  logic                  prescale_legal;
  logic                  wrap;

  assign prescale_legal = prescale_is_legal(32'(prescale));
  assign half_prescale  = prescale_q >> 1;
  assign last_edge_idx  = prescale_q - PRESCALE_W'(1);
  assign wrap           = cnt_enable && (edge_cnt_q == last_edge_idx);

  // Reset masks the flag so a stale counter cannot assert it while cnt_enable is ignored.
  assign last_edge_flag = wrap && !rst;

  // The ratio only reloads while idle, so it is frozen for the whole frame.
  always_comb begin
    prescale_d = prescale_q;
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    if (!cnt_enable) begin
      prescale_d = prescale_legal ? prescale : PRESCALE_RST;
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (wrap) begin
      edge_cnt_d = '0;
      if (bit_cnt_q != BIT_CNT_SAT) begin
        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
      end
    end else begin
      edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prescale_q <= PRESCALE_RST;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      prescale_q <= prescale_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign edge_cnt = edge_cnt_q;
  assign bit_cnt  = bit_cnt_q;

  uart_rx_data_sampler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_data_sampler (
    .clk           (clk),
    .rst           (rst),
    .edge_cnt      (edge_cnt_q),
    .half_prescale (half_prescale),
    .data_samp_en  (data_samp_en),
    .rx_in         (RX_IN),
    .sampled_bit   (sampled_bit),
    .sample_done   (sample_done)
  );

endmodule

// File: tb/tb_uart_rx_edge_sampler.sv
// Randomized frame bench for uart_rx_edge_sampler; the reference tracks frame
// position, ratio and line history and derives every output from them each cycle.
module tb_uart_rx_edge_sampler;

  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cnt_enable = 1'b0;
  logic          data_samp_en = 1'b0;
  logic          rx_in = 1'b1;
  logic [PW-1:0] prescale = PW'(8);
  logic [PW-1:0] edge_cnt;
  logic [3:0]    bit_cnt;
  logic          last_edge_flag;
  logic          sampled_bit;
  logic          sample_done;

  int checks = 0;
  int errors = 0;

  // Reference state: enabled cycles since counters cleared, ratio in force,
  // last voted bit, pending done pulse, previous two line values.
  int m_pos = 0;
  int m_p = 8;
  int m_sb = 1;
  int m_done = 0;
  int m_rx1 = 1;
  int m_rx2 = 1;
  bit m_valid = 1'b0;

  bit cap_en = 1'b0;
  int cap_q[$];
  int frame_no = 0;

  always #5 clk = ~clk;

  uart_rx_edge_sampler #(
    .PRESCALE_W (PW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .prescale       (prescale),
    .RX_IN          (rx_in),
    .data_samp_en   (data_samp_en),
    .cnt_enable     (cnt_enable),
    .edge_cnt       (edge_cnt),
    .bit_cnt        (bit_cnt),
    .last_edge_flag (last_edge_flag),
    .sampled_bit    (sampled_bit),
    .sample_done    (sample_done)
  );

  task automatic check_eq(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", tag, $time, actual, expected);
    end
  endtask

  function automatic int legal_p(input int v);
    return (v == 8 || v == 16 || v == 32) ? v : 8;
  endfunction

  function automatic logic [31:0] make_bits(input int nbits);
    logic [31:0] v;
    v = $urandom;
    v[0] = 1'b0;
    v[nbits-1] = 1'b1;
    return v;
  endfunction

  task automatic drive_cycle(input bit r, input bit ce, input bit dse, input bit rxv, input int pv);
    int e;
    int h;
    int votes;
    bit samp;
    @(posedge clk);
    #1;
    rst = r;
    cnt_enable = ce;
    data_samp_en = dse;
    rx_in = rxv;
    prescale = PW'(pv);
    @(negedge clk);
    e = m_pos % m_p;
    h = m_p / 2;
    if (m_valid) begin
      check_eq("last_edge_flag", int'(last_edge_flag), (!r && ce && e == m_p - 1) ? 1 : 0);
      check_eq("edge_cnt", int'(edge_cnt), e);
      check_eq("bit_cnt", int'(bit_cnt), (m_pos / m_p > 15) ? 15 : m_pos / m_p);
      check_eq("sampled_bit", int'(sampled_bit), m_sb);
      check_eq("sample_done", int'(sample_done), m_done);
    end
    if (cap_en && sample_done) cap_q.push_back(int'(sampled_bit));
    votes = m_rx2 + m_rx1 + int'(rxv);
    samp = !r && dse && (e == h);
    m_rx2 = m_rx1;
    m_rx1 = int'(rxv);
    if (r) begin
      m_pos = 0;
      m_p = 8;
      m_sb = 1;
      m_done = 0;
      m_valid = 1'b1;
    end else begin
      m_done = samp ? 1 : 0;
      if (samp) m_sb = (votes >= 2) ? 1 : 0;
      if (ce) begin
        m_pos++;
      end else begin
        m_pos = 0;
        m_p = legal_p(pv);
      end
    end
  endtask

  task automatic run_gap(input int n, input bit dse, input int pv);
    for (int i = 0; i < n; i++) begin
      drive_cycle(1'b0, 1'b0, dse, 1'b1, (i == n - 1) ? pv : int'($urandom_range(63)));
    end
  endtask

  // Each frame bit holds its nominal level except for random per-cycle flips.
  task automatic run_frame(input int nbits, input logic [31:0] bits, input logic [31:0] dse_bits,
                           input int noise_pct, input int trunc_at, input int reset_at);
    int p;
    int b;
    bit rxv;
    p = m_p;
    frame_no++;
    $display("frame %0d: P=%0d nbits=%0d bits=%h dse=%h noise=%0d trunc=%0d reset=%0d",
             frame_no, p, nbits, bits, dse_bits, noise_pct, trunc_at, reset_at);
    for (int k = 0; k < nbits * p; k++) begin
      if (k == trunc_at) return;
      b = k / p;
      rxv = bits[b];
      if (int'($urandom_range(99)) < noise_pct) rxv = ~rxv;
      if (k == reset_at) begin
        drive_cycle(1'b1, 1'b1, dse_bits[b], rxv, int'($urandom_range(63)));
        return;
      end
      drive_cycle(1'b0, 1'b1, dse_bits[b], rxv, int'($urandom_range(63)));
    end
  endtask

  initial begin
    logic [31:0] a5_bits;
    int exp_a5[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    bit last_full;
    int nb;
    int tr;
    int rs;
    int pv;
    int sel;

    repeat (3) drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 16);

    // Starts straight out of reset, so the reset ratio of 8 must apply.
    a5_bits = {22'h0, 1'b1, 8'hA5, 1'b0};
    cap_en = 1'b1;
    run_frame(10, a5_bits, '1, 0, -1, -1);
    cap_en = 1'b0;
    check_eq("a5_sample_count", cap_q.size(), 10);
    for (int i = 0; i < cap_q.size() && i < 10; i++) check_eq("a5_sampled_seq", cap_q[i], exp_a5[i]);

    run_gap(1, 1'b1, 16);
    run_frame(11, make_bits(11), '1, 15, -1, -1);
    run_gap(1, 1'b1, 32);
    run_frame(10, make_bits(10), '1, 10, -1, -1);
    run_gap(2, 1'b1, 12);
    run_frame(10, make_bits(10), '1, 15, -1, -1);
    run_gap(1, 1'b1, 16);
    run_frame(11, make_bits(11), '1, 10, -1, 4 * 16 + 3);
    run_gap(1, 1'b1, 8);
    run_frame(10, make_bits(10), '1, 0, 3 * 8 + 7, -1);
    run_gap(2, 1'b0, 8);
    run_frame(18, make_bits(18), '1, 10, -1, -1);
    run_gap(1, 1'b1, 16);
    run_frame(11, make_bits(11), $urandom, 15, -1, -1);

    last_full = 1'b1;
    for (int f = 0; f < 30; f++) begin
      sel = int'($urandom_range(3));
      pv = (sel == 0) ? 8 : (sel == 1) ? 16 : (sel == 2) ? 32 : int'($urandom_range(63));
      run_gap(int'($urandom_range(3, 1)), last_full, pv);
      nb = int'($urandom_range(12, 10));
      tr = ($urandom_range(4) == 0) ? int'($urandom_range(nb * m_p - 1, 1)) : -1;
      rs = ($urandom_range(7) == 0) ? int'($urandom_range(nb * m_p - 1, 1)) : -1;
      run_frame(nb, make_bits(nb), ($urandom_range(2) == 0) ? $urandom : '1,
                int'($urandom_range(25)), tr, rs);
      last_full = (tr < 0);
    end
    run_gap(2, 1'b0, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
